// File: rtl/game_input_pio_if.sv
// Avalon-MM slave bus plus interrupt line for the game button PIO.
// The host side (fabric/testbench) uses master; the PIO uses slave.
interface game_input_pio_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata,
    input  irq
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata,
    output irq
  );
endinterface

// File: rtl/game_input_pio.sv
// N-channel button PIO: sync, debounce, press/release capture, autorepeat,
// Avalon-MM register file with a level interrupt.
module game_input_pio #(
  parameter int              N_CH          = 5,
  parameter int              DEBOUNCE_CYC  = 500000,
  parameter int              REPEAT_DELAY  = 25000000,
  parameter int              REPEAT_PERIOD = 5000000,
  parameter logic [N_CH-1:0] INVERT        = '1
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  game_input_pio_if.slave avs
);

  localparam int DBW  = $clog2(DEBOUNCE_CYC);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPW  = $clog2(RMAX);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [RPW-1:0] RD_LAST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_PERIOD - 1);

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] r_lvl;
  logic [DBW-1:0]  r_dcnt [N_CH];
  logic [RPW-1:0]  r_rcnt [N_CH];
  logic [N_CH-1:0] r_rper;
  logic [N_CH-1:0] r_mask;
  logic [N_CH-1:0] r_edge;
  logic [1:0]      r_ctrl;
  logic            r_irq;
  logic [31:0]     r_rdata;

  logic [N_CH-1:0] w_diff;
  logic [N_CH-1:0] w_tog;
  logic [N_CH-1:0] w_press;
  logic [N_CH-1:0] w_rel;
  logic [N_CH-1:0] w_rep;
  logic [N_CH-1:0] w_ev;
  logic [N_CH-1:0] w_w1c;
  logic [N_CH-1:0] w_wd;
  logic [31:0]     w_rd;
  logic            w_wr_mask;
  logic            w_wr_edge;
  logic            w_wr_ctrl;
  logic            w_unused;

  assign w_wd      = avs.avs_writedata[N_CH-1:0];
  assign w_wr_mask = avs.avs_write && (avs.avs_address == 2'd1);
  assign w_wr_edge = avs.avs_write && (avs.avs_address == 2'd2);
  assign w_wr_ctrl = avs.avs_write && (avs.avs_address == 2'd3);
  assign w_w1c     = w_wr_edge ? w_wd : '0;
  assign w_unused  = ^avs.avs_writedata;

  assign w_diff  = r_sync2 ^ r_lvl;
  assign w_press = w_tog & ~r_lvl;
  assign w_rel   = w_tog & r_lvl & {N_CH{r_ctrl[0]}};
  assign w_ev    = w_press | w_rel | w_rep;

  // Per-channel debounce terminal count and autorepeat firing
  always_comb begin
    w_tog = '0;
    w_rep = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_tog[i] = w_diff[i] && (r_dcnt[i] == DB_LAST);
      w_rep[i] = r_ctrl[1] && r_lvl[i] &&
                 (r_rcnt[i] == (r_rper[i] ? RP_LAST : RD_LAST));
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (avs.avs_address)
      2'd0:    w_rd[N_CH-1:0] = r_lvl;
      2'd1:    w_rd[N_CH-1:0] = r_mask;
      2'd2:    w_rd[N_CH-1:0] = r_edge;
      2'd3:    w_rd[1:0]      = r_ctrl;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl   <= '0;
      r_rper  <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
      r_ctrl  <= '0;
      r_irq   <= 1'b0;
      r_rdata <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_dcnt[i] <= '0;
        r_rcnt[i] <= '0;
      end
    end else begin
      r_sync1 <= btn_in ^ INVERT;
      r_sync2 <= r_sync1;
      r_lvl   <= r_lvl ^ w_tog;
      for (int i = 0; i < N_CH; i++) begin
        if (!w_diff[i] || w_tog[i]) begin
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
        // Idle or disabled channels park at the start of the delay phase
        if (!r_lvl[i] || !r_ctrl[1]) begin
          r_rcnt[i] <= '0;
          r_rper[i] <= 1'b0;
        end else if (w_rep[i]) begin
          r_rcnt[i] <= '0;
          r_rper[i] <= 1'b1;
        end else begin
          r_rcnt[i] <= r_rcnt[i] + 1'b1;
        end
      end
      if (w_wr_mask) r_mask <= w_wd;
      if (w_wr_ctrl) r_ctrl <= avs.avs_writedata[1:0];
      r_edge  <= (r_edge & ~w_w1c) | w_ev;
      r_irq   <= |(r_edge & r_mask);
      r_rdata <= avs.avs_read ? w_rd : '0;
    end
  end

  assign btn_level        = r_lvl;
  assign avs.avs_readdata = r_rdata;
  assign avs.irq          = r_irq;

endmodule
